// File: rtl/bit8_1to3_distributor_pkg.sv
// Shared constants for the 8-bit 1-to-3 distributor: widths, lane select codes,
// and the round-robin pointer reset value.
package bit8_1to3_distributor_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 3;

  localparam logic [1:0] SEL_L1 = 2'd0;
  localparam logic [1:0] SEL_L2 = 2'd1;
  localparam logic [1:0] SEL_L3 = 2'd2;
  localparam logic [1:0] SEL_RR = 2'd3;

  localparam logic [1:0] RR_PTR_RST = 2'd0;

endpackage

// File: rtl/bit8_1to3_distributor_demux1to3.sv
// Combinational 1-bit 1-to-3 demux; unselected outputs and code 3 drive 0.
module demux1to3
  import bit8_1to3_distributor_pkg::*;
(
  input  logic       in,
  input  logic [1:0] sel,
  output logic       out1,
  output logic       out2,
  output logic       out3
);

  assign out1 = (sel == SEL_L1) ? in : 1'b0;
  assign out2 = (sel == SEL_L2) ? in : 1'b0;
  assign out3 = (sel == SEL_L3) ? in : 1'b0;

endmodule

// File: rtl/bit8_1to3_distributor.sv
// Registered 1-to-3 byte demux with per-lane valid/ready output registers.
// Build option DISTRIB_ROUND_ROBIN_EN: sel=3 distributes round-robin; otherwise sel=3 drops.
module bit8_1to3_distributor
  import bit8_1to3_distributor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [LANES-1:0]  out_valid,
  input  logic [LANES-1:0]  out_ready,
  output logic [1:0]        rr_ptr,
  output logic [7:0]        drop_cnt
);

  logic [1:0]        tgt;
  logic              accept;
  logic [LANES-1:0]  we;
  logic [DATA_W-1:0] d1, d2, d3;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tgt = sel;
`ifdef DISTRIB_ROUND_ROBIN_EN
    if (sel == SEL_RR) tgt = rr_ptr;
`endif
  end

  // Target code 3 only survives in the drop build, where it is always accepted.
  always_comb begin
    in_ready = 1'b1;
    case (tgt)
      SEL_L1:  in_ready = !out_valid[0] || out_ready[0];
      SEL_L2:  in_ready = !out_valid[1] || out_ready[1];
      SEL_L3:  in_ready = !out_valid[2] || out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready && !rst;
  assign we[0]  = accept && (tgt == SEL_L1);
  assign we[1]  = accept && (tgt == SEL_L2);
  assign we[2]  = accept && (tgt == SEL_L3);

  for (genvar i = 0; i < DATA_W; i++) begin : g_fanout
    demux1to3 u_demux (
      .in   (in[i]),
      .sel  (tgt),
      .out1 (d1[i]),
      .out2 (d2[i]),
      .out3 (d3[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= '0;
    end else begin
      if (we[0]) begin
        out1         <= d1;
        out_valid[0] <= 1'b1;
      end else if (out_ready[0]) begin
        out_valid[0] <= 1'b0;
      end
      if (we[1]) begin
        out2         <= d2;
        out_valid[1] <= 1'b1;
      end else if (out_ready[1]) begin
        out_valid[1] <= 1'b0;
      end
      if (we[2]) begin
        out3         <= d3;
        out_valid[2] <= 1'b1;
      end else if (out_ready[2]) begin
        out_valid[2] <= 1'b0;
      end
    end
  end

`ifdef DISTRIB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= RR_PTR_RST;
    end else if (accept && (sel == SEL_RR)) begin
      rr_ptr <= (rr_ptr == SEL_L3) ? SEL_L1 : rr_ptr + 2'd1;
    end
  end

  assign drop_cnt = '0;
`else
  assign rr_ptr = RR_PTR_RST;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && (sel == SEL_RR) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit8_1to3_distributor.sv
// Directed, table-driven bench for bit8_1to3_distributor; sel=3 sequences follow
// the DISTRIB_ROUND_ROBIN_EN build setting.
module tb_bit8_1to3_distributor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1, out2, out3;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [1:0] rr_ptr;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic [1:0] sel;
    logic [7:0] din;
    logic       vld;
    logic [2:0] rdy;
    logic       exp_ir;
    logic [7:0] exp_o1;
    logic [7:0] exp_o2;
    logic [7:0] exp_o3;
    logic [2:0] exp_ov;
    logic [1:0] exp_rr;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t tbl [14];

  bit8_1to3_distributor dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and state after it.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    sel       = v.sel;
    din       = v.din;
    in_valid  = v.vld;
    out_ready = v.rdy;
    #1 check({tag, ".in_ready"}, in_ready, v.exp_ir);
    @(posedge clk);
    #1;
    check({tag, ".out1"}, out1, v.exp_o1);
    check({tag, ".out2"}, out2, v.exp_o2);
    check({tag, ".out3"}, out3, v.exp_o3);
    check({tag, ".out_valid"}, out_valid, v.exp_ov);
    check({tag, ".rr_ptr"}, rr_ptr, v.exp_rr);
    check({tag, ".drop_cnt"}, drop_cnt, v.exp_drop);
  endtask

  initial begin
    //            rst   sel   din    vld   rdy     ir    o1     o2     o3     ov      rr    drop
    tbl[0]  = '{1'b0, 2'd1, 8'hA5, 1'b1, 3'b000, 1'b1, 8'h00, 8'hA5, 8'h00, 3'b010, 2'd0, 8'd0};
    tbl[1]  = '{1'b0, 2'd1, 8'h5A, 1'b0, 3'b000, 1'b0, 8'h00, 8'hA5, 8'h00, 3'b010, 2'd0, 8'd0};
    tbl[2]  = '{1'b0, 2'd0, 8'h77, 1'b0, 3'b000, 1'b1, 8'h00, 8'hA5, 8'h00, 3'b010, 2'd0, 8'd0};
    tbl[3]  = '{1'b0, 2'd0, 8'hC3, 1'b1, 3'b000, 1'b1, 8'hC3, 8'hA5, 8'h00, 3'b011, 2'd0, 8'd0};
    tbl[4]  = '{1'b0, 2'd0, 8'h3C, 1'b1, 3'b001, 1'b1, 8'h3C, 8'hA5, 8'h00, 3'b011, 2'd0, 8'd0};
    tbl[5]  = '{1'b0, 2'd2, 8'h99, 1'b1, 3'b010, 1'b1, 8'h3C, 8'hA5, 8'h99, 3'b101, 2'd0, 8'd0};
    tbl[6]  = '{1'b0, 2'd2, 8'h88, 1'b1, 3'b000, 1'b0, 8'h3C, 8'hA5, 8'h99, 3'b101, 2'd0, 8'd0};
    tbl[7]  = '{1'b0, 2'd1, 8'h66, 1'b1, 3'b101, 1'b1, 8'h3C, 8'h66, 8'h99, 3'b010, 2'd0, 8'd0};
    tbl[8]  = '{1'b0, 2'd1, 8'h00, 1'b0, 3'b010, 1'b1, 8'h3C, 8'h66, 8'h99, 3'b000, 2'd0, 8'd0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 8'h3C, 8'h66, 8'h99, 3'b000, 2'd0, 8'd0};
    tbl[10] = '{1'b0, 2'd0, 8'hE1, 1'b1, 3'b000, 1'b1, 8'hE1, 8'h66, 8'h99, 3'b001, 2'd0, 8'd0};
    tbl[11] = '{1'b0, 2'd1, 8'hE2, 1'b1, 3'b000, 1'b1, 8'hE1, 8'hE2, 8'h99, 3'b011, 2'd0, 8'd0};
    tbl[12] = '{1'b0, 2'd2, 8'hE3, 1'b1, 3'b000, 1'b1, 8'hE1, 8'hE2, 8'hE3, 3'b111, 2'd0, 8'd0};
    tbl[13] = '{1'b1, 2'd0, 8'hFF, 1'b1, 3'b001, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 2'd0, 8'd0};

    rst = 1'b1; sel = 2'd0; din = 8'h00; in_valid = 1'b0; out_ready = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out1", out1, 8'h00);
    check("reset.out2", out2, 8'h00);
    check("reset.out3", out3, 8'h00);
    check("reset.out_valid", out_valid, 3'b000);
    check("reset.rr_ptr", rr_ptr, 2'd0);
    check("reset.drop_cnt", drop_cnt, 8'd0);
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1 check($sformatf("reset.in_ready_sel%0d", s), in_ready, 1'b1);
    end

    for (int i = 0; i < 14; i++) apply($sformatf("tbl%0d", i), tbl[i]);

`ifdef DISTRIB_ROUND_ROBIN_EN
    // Back-to-back round-robin with all consumers ready.
    apply("rr0", '{1'b0, 2'd3, 8'h11, 1'b1, 3'b111, 1'b1, 8'h11, 8'h00, 8'h00, 3'b001, 2'd1, 8'd0});
    apply("rr1", '{1'b0, 2'd3, 8'h22, 1'b1, 3'b111, 1'b1, 8'h11, 8'h22, 8'h00, 3'b010, 2'd2, 8'd0});
    apply("rr2", '{1'b0, 2'd3, 8'h33, 1'b1, 3'b111, 1'b1, 8'h11, 8'h22, 8'h33, 3'b100, 2'd0, 8'd0});
    apply("rr3", '{1'b0, 2'd3, 8'h44, 1'b1, 3'b111, 1'b1, 8'h44, 8'h22, 8'h33, 3'b001, 2'd1, 8'd0});
    // Lane 2 full with rr_ptr=1: strict order stalls, then drain-and-reload advances.
    apply("rr_fill", '{1'b0, 2'd1, 8'h55, 1'b1, 3'b000, 1'b1, 8'h44, 8'h55, 8'h33, 3'b011, 2'd1, 8'd0});
    apply("rr_stall", '{1'b0, 2'd3, 8'h66, 1'b1, 3'b000, 1'b0, 8'h44, 8'h55, 8'h33, 3'b011, 2'd1, 8'd0});
    apply("rr_go", '{1'b0, 2'd3, 8'h66, 1'b1, 3'b010, 1'b1, 8'h44, 8'h66, 8'h33, 3'b011, 2'd2, 8'd0});
`else
    // Drop mode: sel=3 never touches a lane and the counter saturates at 255.
    apply("drop_fill", '{1'b0, 2'd0, 8'h12, 1'b1, 3'b000, 1'b1, 8'h12, 8'h00, 8'h00, 3'b001, 2'd0, 8'd0});
    apply("drop_idle", '{1'b0, 2'd3, 8'hAA, 1'b0, 3'b000, 1'b1, 8'h12, 8'h00, 8'h00, 3'b001, 2'd0, 8'd0});
    for (int i = 0; i < 300; i++) begin
      vec_t r;
      r = '{1'b0, 2'd3, 8'h00, 1'b1, 3'b000, 1'b1, 8'h12, 8'h00, 8'h00, 3'b001, 2'd0, 8'd0};
      r.din      = i[7:0];
      r.exp_drop = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      apply($sformatf("drop%0d", i), r);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
